// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port RAM; one transaction in flight at a time.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise A has fixed priority.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StRwait, StRdone} state_e;

    state_e            state_q, state_d;
    logic              win_b_q, win_b_d;
    logic              pick_b;
    logic              sel_we;
    logic              a_gnt_d, b_gnt_d, a_rvalid_d, b_rvalid_d;
    logic              ram_wr_d, ram_rd_d, busy_d;
    logic [ADDR_W-1:0] ram_add_d;
    logic [DATA_W-1:0] ram_din_d, a_rdata_d, b_rdata_d;

`ifdef RAM_ARB_RR_EN
    // Set when B should win the next simultaneous request.
    logic prio_b_q, prio_b_d;
    assign pick_b = b_req && (!a_req || prio_b_q);
`else
    assign pick_b = b_req && !a_req;
`endif

    assign sel_we = pick_b ? b_we : a_we;

    always_comb begin
        state_d    = state_q;
        win_b_d    = win_b_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        ram_wr_d   = 1'b0;
        ram_rd_d   = 1'b0;
        ram_add_d  = ram_add;
        ram_din_d  = ram_din;
        a_rdata_d  = a_rdata;
        b_rdata_d  = b_rdata;
`ifdef RAM_ARB_RR_EN
        prio_b_d   = prio_b_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    // Outputs are registered, so the ACCESS-cycle values are loaded here.
                    state_d   = StAccess;
                    win_b_d   = pick_b;
                    ram_wr_d  = sel_we;
                    ram_rd_d  = !sel_we;
                    ram_add_d = pick_b ? b_addr : a_addr;
                    ram_din_d = pick_b ? b_wdata : a_wdata;
                    a_gnt_d   = !pick_b;
                    b_gnt_d   = pick_b;
`ifdef RAM_ARB_RR_EN
                    prio_b_d  = !pick_b;
`endif
                end
            end
            StAccess: state_d = ram_wr ? StIdle : StRwait;
            StRwait: begin
                state_d = StRdone;
                if (win_b_q) begin
                    b_rdata_d  = ram_dout;
                    b_rvalid_d = 1'b1;
                end else begin
                    a_rdata_d  = ram_dout;
                    a_rvalid_d = 1'b1;
                end
            end
            StRdone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            win_b_q  <= 1'b0;
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            ram_wr   <= 1'b0;
            ram_rd   <= 1'b0;
            ram_add  <= '0;
            ram_din  <= '0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            busy     <= 1'b0;
`ifdef RAM_ARB_RR_EN
            prio_b_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            win_b_q  <= win_b_d;
            a_gnt    <= a_gnt_d;
            b_gnt    <= b_gnt_d;
            a_rvalid <= a_rvalid_d;
            b_rvalid <= b_rvalid_d;
            ram_wr   <= ram_wr_d;
            ram_rd   <= ram_rd_d;
            ram_add  <= ram_add_d;
            ram_din  <= ram_din_d;
            a_rdata  <= a_rdata_d;
            b_rdata  <= b_rdata_d;
            busy     <= busy_d;
`ifdef RAM_ARB_RR_EN
            prio_b_q <= prio_b_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: table of single transactions, a scoreboard
// monitor on RAM strobes and rvalid pulses, and hand sequences for contention and reset.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [9:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_wr, ram_rd, busy;
    logic [9:0] ram_add;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    ram_arbiter #(.ADDR_W(10), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_add(ram_add), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model: read data appears the cycle after the ram_rd cycle.
    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_wr) mem[ram_add] <= ram_din;
        if (ram_rd) ram_dout <= mem[ram_add];
    end

    typedef struct {
        logic       is_b;
        logic       we;
        logic [9:0] addr;
        logic [7:0] data;
    } acc_t;
    typedef struct {
        logic       is_b;
        logic [7:0] data;
    } rd_t;
    typedef struct {
        logic       is_b;
        logic       we;
        logic [9:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rdata;
    } vec_t;

    acc_t acc_q[$];
    rd_t  rd_q[$];
    acc_t mon_acc;
    rd_t  mon_rd;

    int n_checks = 0;
    int n_fail = 0;
    int overlap_cnt = 0;
    logic [7:0] exp_a_rdata, exp_b_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every RAM access and every rvalid pulse must match the next queued entry.
    always @(negedge clk) begin
        if (ram_wr && ram_rd) overlap_cnt++;
        if (ram_wr || ram_rd) begin
            if (acc_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_access: got wr=%0b rd=%0b add=0x%0h, expected none",
                         ram_wr, ram_rd, ram_add);
            end else begin
                mon_acc = acc_q.pop_front();
                check("acc_we", 32'(ram_wr), 32'(mon_acc.we));
                check("acc_addr", 32'(ram_add), 32'(mon_acc.addr));
                if (mon_acc.we) check("acc_din", 32'(ram_din), 32'(mon_acc.data));
                check("acc_gnt", 32'({a_gnt, b_gnt}), mon_acc.is_b ? 32'd1 : 32'd2);
            end
        end
        if (a_rvalid || b_rvalid) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got a=%0b b=%0b, expected none",
                         a_rvalid, b_rvalid);
            end else begin
                mon_rd = rd_q.pop_front();
                check("rv_who", 32'({a_rvalid, b_rvalid}), mon_rd.is_b ? 32'd1 : 32'd2);
                check("rv_data", 32'(mon_rd.is_b ? b_rdata : a_rdata), 32'(mon_rd.data));
            end
        end
    end

    task automatic drive(input logic is_b, input logic we, input logic [9:0] addr,
                         input logic [7:0] data);
        if (is_b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        a_req = 1'b0;
        b_req = 1'b0;
        drive(v.is_b, v.we, v.addr, v.data);
        acc_q.push_back('{v.is_b, v.we, v.addr, v.data});
        if (!v.we) rd_q.push_back('{v.is_b, v.exp_rdata});
        tick();
        check({tag, "_gnt"}, 32'({a_gnt, b_gnt}), v.is_b ? 32'd1 : 32'd2);
        check({tag, "_strobe"}, 32'({ram_wr, ram_rd}), v.we ? 32'd2 : 32'd1);
        a_req = 1'b0;
        b_req = 1'b0;
        if (!v.we) begin
            tick();
            tick();
            check({tag, "_rvalid"}, 32'({a_rvalid, b_rvalid}), v.is_b ? 32'd1 : 32'd2);
            if (v.is_b) exp_b_rdata = v.exp_rdata;
            else        exp_a_rdata = v.exp_rdata;
        end
        tick();
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_a_rdata"}, 32'(a_rdata), 32'(exp_a_rdata));
        check({tag, "_b_rdata"}, 32'(b_rdata), 32'(exp_b_rdata));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_a_rdata = 8'h00;
        exp_b_rdata = 8'h00;
    endtask

    vec_t vecs[9];
    logic [1:0] exp_gnt[4];
    logic [1:0] gnt_seen;
    int gcount;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

        vecs[0] = '{1'b0, 1'b1, 10'd9,   8'hB9, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 10'd9,   8'h00, 8'hB9};
        vecs[2] = '{1'b1, 1'b1, 10'd6,   8'h98, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 10'd6,   8'h00, 8'h98};
        vecs[4] = '{1'b0, 1'b1, 10'h3FF, 8'hFF, 8'h00};
        vecs[5] = '{1'b0, 1'b0, 10'h3FF, 8'h00, 8'hFF};
        vecs[6] = '{1'b1, 1'b1, 10'd0,   8'h5A, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 10'd0,   8'h00, 8'h5A};
        vecs[8] = '{1'b0, 1'b1, 10'd5,   8'h11, 8'h00};

        do_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
        check("rst_strobes", 32'({ram_wr, ram_rd}), 32'd0);
        check("rst_add", 32'(ram_add), 32'd0);
        check("rst_din", 32'(ram_din), 32'd0);
        check("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);

        for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("row%0d", i));

        // Last grant went to A, so a round-robin pointer now favours B until reset.
        do_reset();
`ifdef RAM_ARB_RR_EN
        exp_gnt = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        exp_gnt = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
        for (int g = 0; g < 4; g++) begin
            if (exp_gnt[g] == 2'b01) acc_q.push_back('{1'b1, 1'b1, 10'd6, 8'h66});
            else                     acc_q.push_back('{1'b0, 1'b1, 10'd5, 8'h55});
        end
        drive(1'b0, 1'b1, 10'd5, 8'h55);
        drive(1'b1, 1'b1, 10'd6, 8'h66);
        gcount = 0;
        for (int c = 0; c < 20 && gcount < 4; c++) begin
            tick();
            if (a_gnt || b_gnt) begin
                check($sformatf("contend_gnt%0d", gcount), 32'({a_gnt, b_gnt}),
                      32'(exp_gnt[gcount]));
                gcount++;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("contend_count", 32'(gcount), 32'd4);
        tick();
        check("contend_idle", 32'(busy), 32'd0);

        // A write queued against a B read of the same data.
        run_txn('{1'b0, 1'b1, 10'd6, 8'h98, 8'h00}, "pre6");
`ifdef RAM_ARB_RR_EN
        acc_q.push_back('{1'b1, 1'b0, 10'd6, 8'h00});
        acc_q.push_back('{1'b0, 1'b1, 10'd7, 8'h77});
`else
        acc_q.push_back('{1'b0, 1'b1, 10'd7, 8'h77});
        acc_q.push_back('{1'b1, 1'b0, 10'd6, 8'h00});
`endif
        rd_q.push_back('{1'b1, 8'h98});
        drive(1'b0, 1'b1, 10'd7, 8'h77);
        drive(1'b1, 1'b0, 10'd6, 8'h00);
        gnt_seen = 2'b00;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (a_gnt) begin a_req = 1'b0; gnt_seen[1] = 1'b1; end
            if (b_gnt) begin b_req = 1'b0; gnt_seen[0] = 1'b1; end
            if (gnt_seen == 2'b11 && !busy) break;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("mix_both_granted", 32'(gnt_seen), 32'd3);
        check("mix_idle", 32'(busy), 32'd0);
        check("mix_b_rdata", 32'(b_rdata), 32'h98);
        exp_b_rdata = 8'h98;
        run_txn('{1'b0, 1'b0, 10'd7, 8'h00, 8'h77}, "mix_a_written");

        // Reset while an A read sits in RWAIT: the read must vanish.
        acc_q.push_back('{1'b0, 1'b0, 10'd9, 8'h00});
        drive(1'b0, 1'b0, 10'd9, 8'h00);
        tick();
        a_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_a_rdata = 8'h00;
        exp_b_rdata = 8'h00;
        check("rwait_rst_busy", 32'(busy), 32'd0);
        check("rwait_rst_strobes", 32'({ram_wr, ram_rd}), 32'd0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rwait_rst_no_rvalid%0d", c), 32'(a_rvalid), 32'd0);
            tick();
        end
        check("rwait_rst_rdata", 32'(a_rdata), 32'd0);
        run_txn('{1'b0, 1'b0, 10'd7, 8'h00, 8'h77}, "after_rst");

        // Reset during ACCESS drops the strobe on the next cycle.
        acc_q.push_back('{1'b0, 1'b1, 10'h100, 8'h42});
        drive(1'b0, 1'b1, 10'h100, 8'h42);
        tick();
        a_req = 1'b0;
        check("acc_rst_wr_before", 32'(ram_wr), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("acc_rst_wr_after", 32'(ram_wr), 32'd0);
        check("acc_rst_busy", 32'(busy), 32'd0);
        tick();

        check("no_concurrent_strobes", 32'(overlap_cnt), 32'd0);
        check("acc_queue_drained", 32'(acc_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 a_req, b_req  input  1 each  transaction request from requester A / B.
REQ-006 a_we, b_we  input  1 each  1 = write, 0 = read.
REQ-007 a_addr, b_addr  input  ADDR_W each  target address.
REQ-008 a_wdata, b_wdata  input  DATA_W each  write data.
REQ-009 a_gnt, b_gnt  output  1 each  one-cycle grant pulse; request accepted.
REQ-010 a_rvalid, b_rvalid  output  1 each  one-cycle read-data-valid pulse.
REQ-011 a_rdata, b_rdata  output  DATA_W each  read data, held until next read completes for that requester.
REQ-012 ram_wr, ram_rd  output  1 each  RAM write / read strobes.
REQ-013 ram_add  output  ADDR_W  RAM address.
REQ-014 ram_din  output  DATA_W  RAM write data.
REQ-015 ram_dout  input  DATA_W  RAM read data, valid the cycle after the ram_rd cycle.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS, RWAIT, RDONE; all outputs SHALL be registered.
REQ-018 IDLE: if any req is high, select a winner, capture its we/addr/wdata, go to ACCESS; else stay.
REQ-019 ACCESS (one cycle): drive captured ram_add and ram_din, assert ram_wr if write else ram_rd, pulse winner's gnt; next state IDLE for write, RWAIT for read.
REQ-020 RWAIT: ram_wr = ram_rd = 0; capture ram_dout into winner's rdata at end of cycle; go to RDONE.
REQ-021 RDONE: pulse winner's rvalid with the captured rdata; go to IDLE.
REQ-022 Latency: req sampled in IDLE at edge N -> gnt and strobe in cycle N+1; read rvalid in cycle N+3; write throughput one per 2 cycles, read one per 4.
REQ-023 ram_wr and ram_rd SHALL never be high in the same cycle; both 0 outside ACCESS.
REQ-024 Requesters hold req/we/addr/wdata stable until gnt; req still high in the IDLE following gnt is a new request.
REQ-025 Only one transaction SHALL be in flight; requests arriving in ACCESS/RWAIT/RDONE wait, none dropped.
REQ-026 Only the winner's gnt/rvalid pulse; the other requester's rdata SHALL be unchanged.
REQ-027 ram_add/ram_din SHALL retain their last value outside ACCESS.

Reset
REQ-028 rst high at a clock edge SHALL force IDLE and clear gnt, rvalid, ram_wr, ram_rd, busy, ram_add, ram_din, a_rdata, b_rdata to 0, and set the priority pointer to favour A.
REQ-029 Reset mid-read SHALL discard the transaction: no rvalid issued afterward; reset during ACCESS SHALL deassert strobes in the next cycle.

Configuration
REQ-030 Macro RAM_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not granted most recently wins; pointer updates on every grant.
REQ-031 RAM_ARB_RR_EN undefined: fixed priority, A always wins simultaneous requests; no pointer logic.

Verification
REQ-032 After reset, a_req=1, a_we=1, a_addr=9, a_wdata=0xB9 -> cycle after IDLE: ram_wr=1, ram_add=9, ram_din=0xB9, a_gnt=1, ram_rd=0.
REQ-033 Then a_req=1, a_we=0, a_addr=9 -> a_gnt in N+1, ram_rd=1 with ram_add=9, a_rvalid in N+3 with a_rdata=0xB9; b_rdata stays 0.
REQ-034 A and B both request every cycle, writes to 5 and 6 (RR_EN) -> grants alternate A,B,A,B starting with A; without RR_EN -> A granted every time while it requests, B starved.
REQ-035 B read of addr 6 (data 0x98) while A write pending -> one transaction at a time, ram_wr/ram_rd never concurrent, b_rvalid with b_rdata=0x98, A's write still completes.
REQ-036 rst asserted during RWAIT of A read -> next cycle busy=0, all strobes 0, no a_rvalid ever; subsequent A request serviced normally.
